// File: rtl/unpacked_win_pkg.sv
// Shared types and default sizes for the unpacked window writer.
package unpacked_win_pkg;

  localparam int ELEM_W    = 4;
  localparam int NELEM_DEF = 5;
  localparam int WIN_DEF   = 3;

  typedef logic [ELEM_W-1:0] elem_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } wstate_t;

endpackage

// File: rtl/unpacked_window_writer_if.sv
// Producer-side element stream and consumer-side array/window bus of the writer.
interface unpacked_window_writer_if #(
  parameter int W     = unpacked_win_pkg::ELEM_W,
  parameter int NELEM = unpacked_win_pkg::NELEM_DEF,
  parameter int WIN   = unpacked_win_pkg::WIN_DEF
);
  localparam int BW = $clog2(NELEM);

  // Both sides use valid/ready: a transfer happens on a rising clk edge where
  // valid && ready; the source holds its payload and valid until that edge.
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [BW-1:0]        out_base;
  logic [W-1:0]         out_win [WIN];
  logic [NELEM*W-1:0]   out_flat;
  logic                 out_err;

  modport master (
    output in_valid, in_data, out_ready, out_base,
    input  in_ready, out_valid, out_win, out_flat, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, out_base,
    output in_ready, out_valid, out_win, out_flat, out_err
  );
endinterface

// File: rtl/unpacked_win_select.sv
// Window part-select over the element array with range error.
// Define UNPACKED_WIN_DESCENDING_EN for -: (descending) window semantics.
module unpacked_win_select #(
  parameter int W     = 4,
  parameter int NELEM = 5,
  parameter int WIN   = 3,
  parameter int BW    = $clog2(NELEM)
) (
  input  logic [W-1:0]  mem [NELEM],
  input  logic [BW-1:0] base,
  output logic [W-1:0]  win [WIN],
  output logic          err
);

`ifdef UNPACKED_WIN_DESCENDING_EN
  always_comb begin
    logic [BW:0] sum;
    logic [BW:0] idx;
    win = '{default: '0};
    sum = '0;
    idx = '0;
    err = ({1'b0, base} < (BW+1)'(WIN-1)) || ({1'b0, base} > (BW+1)'(NELEM-1));
    for (int i = 0; i < WIN; i++) begin
      // base-WIN+1+i rearranged as (base+i+1)-WIN so nothing goes negative
      sum = {1'b0, base} + (BW+1)'(i + 1);
      if (sum >= (BW+1)'(WIN)) begin
        idx = sum - (BW+1)'(WIN);
        if (idx < (BW+1)'(NELEM)) win[i] = mem[idx[BW-1:0]];
      end
    end
  end
`else
  always_comb begin
    logic [BW:0] idx;
    win = '{default: '0};
    idx = '0;
    err = ({1'b0, base} + (BW+1)'(WIN)) > (BW+1)'(NELEM);
    for (int i = 0; i < WIN; i++) begin
      idx = {1'b0, base} + (BW+1)'(i);
      if (idx < (BW+1)'(NELEM)) win[i] = mem[idx[BW-1:0]];
    end
  end
`endif

endmodule

// File: rtl/unpacked_window_writer.sv
// Collects NELEM elements, then offers the full array (flat + window) until taken.
// Window direction follows UNPACKED_WIN_DESCENDING_EN (see unpacked_win_select).
module unpacked_window_writer
  import unpacked_win_pkg::*;
#(
  parameter int W     = ELEM_W,
  parameter int NELEM = NELEM_DEF,
  parameter int WIN   = WIN_DEF
) (
  input  logic    clk,
  input  logic    rst,
  unpacked_window_writer_if.slave bus,
  output wstate_t dbg_state
);
  localparam int BW = $clog2(NELEM);
  localparam logic [BW-1:0] LAST = BW'(NELEM - 1);

  wstate_t       state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mem_q [NELEM];
  logic [W-1:0]  mem_d [NELEM];
  logic [W-1:0]  sel_win [WIN];
  logic          sel_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          mem_d[cnt_q] = bus.in_data;
          if (cnt_q == LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // Release only; the first new element is taken the cycle after.
        if (bus.out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  unpacked_win_select #(
    .W(W), .NELEM(NELEM), .WIN(WIN), .BW(BW)
  ) u_select (
    .mem  (mem_q),
    .base (bus.out_base),
    .win  (sel_win),
    .err  (sel_err)
  );

  always_comb begin
    bus.in_ready  = (state_q == FILL) && !rst;
    bus.out_valid = (state_q == HOLD);
    bus.out_err   = 1'b0;
    bus.out_flat  = '0;
    bus.out_win   = '{default: '0};
    dbg_state     = state_q;
    if (state_q == HOLD) begin
      bus.out_err = sel_err;
      bus.out_win = sel_win;
      for (int i = 0; i < NELEM; i++) bus.out_flat[i*W +: W] = mem_q[i];
    end
  end

endmodule

// File: tb/tb_unpacked_window_writer.sv
// Randomized self-checking bench for unpacked_window_writer against a queue-based model.
module tb_unpacked_window_writer;
  import unpacked_win_pkg::*;

  localparam int W  = 4;
  localparam int NE = 5;
  localparam int WN = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wstate_t dbg_state;

  unpacked_window_writer_if #(.W(W), .NELEM(NE), .WIN(WN)) bus ();

  unpacked_window_writer #(.W(W), .NELEM(NE), .WIN(WN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // scoreboard / model state
  int                 n_checks = 0;
  int                 n_fail   = 0;
  logic [NE*W-1:0]    exp_q [$];
  int                 fill_q [$];
  int                 m_mem [NE];
  bit                 m_full = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_win(int base, int i);
    int idx;
`ifdef UNPACKED_WIN_DESCENDING_EN
    idx = base - WN + 1 + i;
`else
    idx = base + i;
`endif
    if (idx >= 0 && idx < NE) return m_mem[idx];
    return 0;
  endfunction

  function automatic bit ref_err(int base);
`ifdef UNPACKED_WIN_DESCENDING_EN
    return (base < WN - 1) || (base > NE - 1);
`else
    return (base + WN) > NE;
`endif
  endfunction

  function automatic logic [NE*W-1:0] ref_flat();
    logic [NE*W-1:0] f;
    int v;
    f = '0;
    for (int i = 0; i < NE; i++) begin
      v = m_mem[i];
      f[i*W +: W] = v[W-1:0];
    end
    return f;
  endfunction

  task automatic check_outputs();
    check("in_ready", bus.in_ready, !m_full);
    check("out_valid", bus.out_valid, m_full);
    check("dbg_state", dbg_state, m_full ? HOLD : FILL);
    check("out_flat", bus.out_flat, m_full ? ref_flat() : '0);
    check("out_err", bus.out_err, m_full ? ref_err(int'(bus.out_base)) : 1'b0);
    for (int i = 0; i < WN; i++)
      check($sformatf("out_win[%0d]", i), bus.out_win[i],
            m_full ? ref_win(int'(bus.out_base), i) : 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_flat"}, bus.out_flat, '0);
    check({tag, "_out_err"}, bus.out_err, 1'b0);
    for (int i = 0; i < WN; i++) check({tag, "_out_win"}, bus.out_win[i], '0);
  endtask

  // One clock: check at mid-cycle, then advance model across the rising edge.
  task automatic step();
    bit acc, rel;
    #1;
    check_outputs();
    acc = bus.in_valid && !m_full;
    rel = m_full && bus.out_ready;
    if (rel) begin
      if (exp_q.size() == 0) check("sb_empty", 1, 0);
      else check("sb_flat", bus.out_flat, exp_q.pop_front());
    end
    @(posedge clk);
    if (rel) m_full = 1'b0;
    if (acc) begin
      fill_q.push_back(int'(bus.in_data));
      if (fill_q.size() == NE) begin
        for (int i = 0; i < NE; i++) m_mem[i] = fill_q[i];
        fill_q.delete();
        m_full = 1'b1;
        exp_q.push_back(ref_flat());
      end
    end
    @(negedge clk);
  endtask

  // driver tasks
  task automatic feed(input logic [W-1:0] d);
    int k;
    k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (m_full && k < 30) begin
      step();
      k++;
    end
    if (k == 30) check("feed_timeout", 1, 0);
    else step();
    bus.in_valid = 1'b0;
  endtask

  task automatic release_array();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic model_reset();
    fill_q.delete();
    exp_q.delete();
    m_full = 1'b0;
    for (int i = 0; i < NE; i++) m_mem[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.out_base  = '0;
    model_reset();
    @(negedge clk);
    check_all_zero("reset");
    check("reset_state", dbg_state, FILL);
    @(negedge clk);
    rst = 1'b0;
    step();

    // back-to-back fill, array held under backpressure
    for (int d = 1; d <= NE; d++) feed(W'(d));
    #1;
    check("fill_latency_valid", bus.out_valid, 1'b1);
    check("flat_54321", bus.out_flat, 20'h54321);
    check("held_in_ready", bus.in_ready, 1'b0);

    // window sweep over every base with in_valid asserted (must be ignored)
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    for (int b = 0; b < (1 << $clog2(NE)); b++) begin
      bus.out_base = 3'(b);
      step();
    end
`ifdef UNPACKED_WIN_DESCENDING_EN
    bus.out_base = 3'd3;
    #1;
    check("desc_b3_w0", bus.out_win[0], 4'd2);
    check("desc_b3_w1", bus.out_win[1], 4'd3);
    check("desc_b3_w2", bus.out_win[2], 4'd4);
    check("desc_b3_err", bus.out_err, 1'b0);
    bus.out_base = 3'd1;
    #1;
    check("desc_b1_err", bus.out_err, 1'b1);
    check("desc_b1_w0", bus.out_win[0], 4'd0);
    check("desc_b1_w1", bus.out_win[1], 4'd1);
    check("desc_b1_w2", bus.out_win[2], 4'd2);
`else
    bus.out_base = 3'd2;
    #1;
    check("asc_b2_w0", bus.out_win[0], 4'd3);
    check("asc_b2_w2", bus.out_win[2], 4'd5);
    check("asc_b2_err", bus.out_err, 1'b0);
    bus.out_base = 3'd3;
    #1;
    check("asc_b3_w0", bus.out_win[0], 4'd4);
    check("asc_b3_w1", bus.out_win[1], 4'd5);
    check("asc_b3_w2", bus.out_win[2], 4'd0);
    check("asc_b3_err", bus.out_err, 1'b1);
`endif
    check("hold_flat_stable", bus.out_flat, 20'h54321);
    bus.in_valid = 1'b0;
    bus.out_base = '0;

    // release, then refill A..E
    release_array();
    #1;
    check("release_to_fill", bus.in_ready, 1'b1);
    for (int d = 10; d <= 14; d++) feed(W'(d));
    #1;
    check("flat_edcba", bus.out_flat, 20'hEDCBA);
    release_array();

    // asynchronous reset in the middle of a fill
    feed(4'd7);
    feed(4'd8);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int d = 1; d <= NE; d++) feed(W'(d));
    #1;
    check("flat_after_rst", bus.out_flat, 20'h54321);
    release_array();

    // gapped input: idle cycle between each element
    for (int d = 6; d <= 10; d++) begin
      feed(W'(d));
      step();
    end
    #1;
    check("flat_gapped", bus.out_flat, 20'hA9876);
    release_array();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = W'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) == 0);
      bus.out_base  = 3'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
